// File: rtl/instr_decode.sv
// Instruction register and decode stage: latches the fetched word, registers the command code
// and keeps instruction counters. Optional sticky illegal trap under `ILLEGAL_TRAP_EN.
module instr_decode #(
  parameter int unsigned COUNT_W = 32,
  parameter int unsigned ILL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               irWe,
  input  logic [31:0]        instr,
  input  logic               trapClr,
  output logic [3:0]         cmd,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm,
  output logic [25:0]        jaddr,
  output logic               illegal,
  output logic [COUNT_W-1:0] instrCount,
  output logic [ILL_W-1:0]   illegalCount,
  output logic               trap
);

  localparam logic [3:0] CmdLw      = 4'd0;
  localparam logic [3:0] CmdSw      = 4'd1;
  localparam logic [3:0] CmdJ       = 4'd2;
  localparam logic [3:0] CmdJr      = 4'd3;
  localparam logic [3:0] CmdJal     = 4'd4;
  localparam logic [3:0] CmdBeq     = 4'd5;
  localparam logic [3:0] CmdBne     = 4'd6;
  localparam logic [3:0] CmdXori    = 4'd7;
  localparam logic [3:0] CmdAddi    = 4'd8;
  localparam logic [3:0] CmdAdd     = 4'd9;
  localparam logic [3:0] CmdSub     = 4'd10;
  localparam logic [3:0] CmdSlt     = 4'd11;
  localparam logic [3:0] CmdIllegal = 4'd15;

  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);
  localparam logic [ILL_W-1:0]   IllOne   = ILL_W'(1);

  logic [31:0]        ir_q;
  logic [3:0]         cmd_q;
  logic               illegal_q;
  logic [COUNT_W-1:0] instr_count_q;
  logic [ILL_W-1:0]   illegal_count_q;

  logic [5:0] op;
  logic [5:0] funct;
  logic [3:0] dec_cmd;
  logic       dec_illegal;

  // Decode the incoming word, not the held IR, so cmd is valid one cycle after irWe.
  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    dec_cmd = CmdIllegal;
    case (op)
      6'h23: dec_cmd = CmdLw;
      6'h2B: dec_cmd = CmdSw;
      6'h02: dec_cmd = CmdJ;
      6'h03: dec_cmd = CmdJal;
      6'h04: dec_cmd = CmdBeq;
      6'h05: dec_cmd = CmdBne;
      6'h0E: dec_cmd = CmdXori;
      6'h08: dec_cmd = CmdAddi;
      6'h00: begin
        case (funct)
          6'h08:   dec_cmd = CmdJr;
          6'h20:   dec_cmd = CmdAdd;
          6'h22:   dec_cmd = CmdSub;
          6'h2A:   dec_cmd = CmdSlt;
          default: dec_cmd = CmdIllegal;
        endcase
      end
      default: dec_cmd = CmdIllegal;
    endcase
  end

  assign dec_illegal = (dec_cmd == CmdIllegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q      <= 32'h0;
      cmd_q     <= CmdIllegal;
      illegal_q <= 1'b0;
    end else if (irWe) begin
      ir_q      <= instr;
      cmd_q     <= dec_cmd;
      illegal_q <= dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= '0;
    end else if (irWe) begin
      instr_count_q <= instr_count_q + CountOne;
    end
  end

  // Saturating so a storm of bad fetches never aliases back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count_q <= '0;
    end else if (irWe && dec_illegal && (illegal_count_q != '1)) begin
      illegal_count_q <= illegal_count_q + IllOne;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;

  // Set has priority over clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (irWe && dec_illegal) begin
      trap_q <= 1'b1;
    end else if (trapClr) begin
      trap_q <= 1'b0;
    end
  end

  assign trap = trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trapClr;
  assign trap            = 1'b0;
`endif

  logic [5:0] unused_ir_op;
  assign unused_ir_op = ir_q[31:26];

  assign cmd          = cmd_q;
  assign illegal      = illegal_q;
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign imm          = ir_q[15:0];
  assign jaddr        = ir_q[25:0];
  assign instrCount   = instr_count_q;
  assign illegalCount = illegal_count_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode with small counters; trap expectations follow
// whether ILLEGAL_TRAP_EN is defined for the build.
module tb_instr_decode;

  localparam int unsigned CW = 4;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          irWe;
  logic [31:0]   instr;
  logic          trapClr;
  logic [3:0]    cmd;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   jaddr;
  logic          illegal;
  logic [CW-1:0] instrCount;
  logic [IW-1:0] illegalCount;
  logic          trap;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0]   m_ir;
  logic [3:0]    m_cmd;
  logic          m_ill;
  int            m_cnt;
  int            m_illcnt;
  logic          m_trap;

  instr_decode #(.COUNT_W(CW), .ILL_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .irWe         (irWe),
    .instr        (instr),
    .trapClr      (trapClr),
    .cmd          (cmd),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .imm          (imm),
    .jaddr        (jaddr),
    .illegal      (illegal),
    .instrCount   (instrCount),
    .illegalCount (illegalCount),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_cmd(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    case (op)
      6'h23: return 4'd0;
      6'h2B: return 4'd1;
      6'h02: return 4'd2;
      6'h03: return 4'd4;
      6'h04: return 4'd5;
      6'h05: return 4'd6;
      6'h0E: return 4'd7;
      6'h08: return 4'd8;
      6'h00: begin
        if (fn == 6'h08) return 4'd3;
        if (fn == 6'h20) return 4'd9;
        if (fn == 6'h22) return 4'd10;
        if (fn == 6'h2A) return 4'd11;
        return 4'd15;
      end
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic trap_enabled();
`ifdef ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ir = 32'h0; m_cmd = 4'hF; m_ill = 1'b0;
    m_cnt = 0; m_illcnt = 0; m_trap = 1'b0;
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, update model, return at negedge.
  task automatic step(input logic we, input logic [31:0] w, input logic clr);
    irWe = we; instr = w; trapClr = clr;
    @(posedge clk);
    if (we) begin
      m_ir  = w;
      m_cmd = ref_cmd(w);
      m_ill = (m_cmd == 4'd15);
      m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_ill && m_illcnt < (1 << IW) - 1) m_illcnt++;
    end
    if (trap_enabled()) begin
      if (we && m_ill) m_trap = 1'b1;
      else if (clr) m_trap = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [8] = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0E, 6'h08};
    logic [5:0] fns [5] = '{6'h08, 6'h20, 6'h22, 6'h2A, 6'h3F};
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: ;
      1: w[31:26] = ops[$urandom_range(0, 7)];
      default: begin
        w[31:26] = 6'h00;
        w[5:0]   = fns[$urandom_range(0, 4)];
      end
    endcase
    return w;
  endfunction

  task automatic test_reset();
    step(1'b1, 32'hFC000000, 1'b0);
    step(1'b1, 32'h00432020, 1'b0);
    #3 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({cmd, illegal, instrCount, illegalCount, trap, jaddr} !==
        {4'hF, 1'b0, {CW{1'b0}}, {IW{1'b0}}, 1'b0, 26'h0}) begin
      failures++;
      $display("FAIL reset: got cmd=%0d ill=%0b ic=%0d lc=%0d trap=%0b ja=%h want 15/0/0/0/0/0",
               cmd, illegal, instrCount, illegalCount, trap, jaddr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode_sweep();
    logic [31:0] words [12] = '{32'h8C430004, 32'hAC430004, 32'h08000010, 32'h0C000010,
                                32'h03E00008, 32'h10430002, 32'h14430002, 32'h3843FFFF,
                                32'h20430005, 32'h00432020, 32'h00432022, 32'h0043202A};
    logic [3:0] exp [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                             4'd10, 4'd11};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, words[i], 1'b0);
      checks++;
      if (cmd !== exp[i] || illegal !== 1'b0) begin
        failures++;
        $display("FAIL sweep_cmd[%0d]: got cmd=%0d ill=%0b want cmd=%0d ill=0",
                 i, cmd, illegal, exp[i]);
      end
      if (i != 2 && i != 3 && i != 4) begin
        checks++;
        if (rs !== 5'd2 || rt !== 5'd3) begin
          failures++;
          $display("FAIL sweep_fields[%0d]: got rs=%0d rt=%0d want rs=2 rt=3", i, rs, rt);
        end
      end
      if (i == 7) begin
        checks++;
        if (imm !== 16'hFFFF) begin
          failures++;
          $display("FAIL sweep_imm: got %h want ffff", imm);
        end
      end
    end
    checks++;
    if (instrCount !== CW'(12)) begin
      failures++;
      $display("FAIL sweep_count: got %0d want 12", instrCount);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h00000000, 1'b0);
    checks++;
    if ({cmd, rs, rt, rd, imm, jaddr, instrCount, illegalCount} !==
        {m_cmd, m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[15:0], m_ir[25:0],
         CW'(m_cnt), IW'(m_illcnt)}) begin
      failures++;
      $display("FAIL hold: got cmd=%0d jaddr=%h ic=%0d lc=%0d want cmd=%0d jaddr=%h ic=%0d lc=%0d",
               cmd, jaddr, instrCount, illegalCount, m_cmd, m_ir[25:0], m_cnt, m_illcnt);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 32'h00000000, 1'b0);
    checks++;
    if (cmd !== 4'd15 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_zero: got cmd=%0d ill=%0b want 15/1", cmd, illegal);
    end
    step(1'b1, 32'hFC000000, 1'b0);
    checks++;
    if (cmd !== 4'd15 || illegal !== 1'b1 || illegalCount !== IW'(2) || trap !== trap_enabled())
    begin
      failures++;
      $display("FAIL illegal_fc: got cmd=%0d ill=%0b lc=%0d trap=%0b want 15/1/2/%0b",
               cmd, illegal, illegalCount, trap, trap_enabled());
    end
    step(1'b1, 32'h00432020, 1'b0);
    checks++;
    if (cmd !== 4'd9 || illegal !== 1'b0 || trap !== m_trap) begin
      failures++;
      $display("FAIL trap_sticky: got cmd=%0d ill=%0b trap=%0b want 9/0/%0b",
               cmd, illegal, trap, m_trap);
    end
    step(1'b0, 32'h00432020, 1'b1);
    checks++;
    if (trap !== 1'b0) begin
      failures++;
      $display("FAIL trap_clear: got %0b want 0", trap);
    end
    step(1'b1, 32'hFFFFFFFF, 1'b1);
    checks++;
    if (trap !== trap_enabled() || illegal !== 1'b1) begin
      failures++;
      $display("FAIL trap_set_wins: got trap=%0b ill=%0b want %0b/1", trap, illegal,
               trap_enabled());
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < (1 << IW) + 3; i++) step(1'b1, {6'h3F, 26'($urandom)}, 1'b0);
    checks++;
    if (illegalCount !== {IW{1'b1}} || instrCount !== CW'(((1 << IW) + 3) % (1 << CW))) begin
      failures++;
      $display("FAIL ill_saturate: got lc=%0d ic=%0d want lc=15 ic=%0d", illegalCount,
               instrCount, ((1 << IW) + 3) % (1 << CW));
    end
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 32'h00432022, 1'b0);
    checks++;
    if (instrCount !== CW'(1) || illegalCount !== '0) begin
      failures++;
      $display("FAIL count_wrap: got ic=%0d lc=%0d want ic=1 lc=0", instrCount, illegalCount);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic        we, clr;
    for (int i = 0; i < 300; i++) begin
      w   = rand_word();
      we  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 4) == 0);
      step(we, w, clr);
      checks++;
      if ({cmd, illegal, rs, rt, rd, imm, jaddr, instrCount, illegalCount, trap} !==
          {m_cmd, m_ill, m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[15:0], m_ir[25:0],
           CW'(m_cnt), IW'(m_illcnt), m_trap}) begin
        failures++;
        $display("FAIL random[%0d] ir=%h: got cmd=%0d ill=%0b ja=%h ic=%0d lc=%0d trap=%0b want cmd=%0d ill=%0b ja=%h ic=%0d lc=%0d trap=%0b",
                 i, m_ir, cmd, illegal, jaddr, instrCount, illegalCount, trap,
                 m_cmd, m_ill, m_ir[25:0], m_cnt, m_illcnt, m_trap);
      end
    end
  endtask

  task automatic test_reset_burst();
    step(1'b1, 32'hFC000000, 1'b0);
    step(1'b1, 32'h8C430004, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({cmd, illegal, instrCount, illegalCount, trap, imm} !==
        {4'hF, 1'b0, {CW{1'b0}}, {IW{1'b0}}, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL burst_reset: got cmd=%0d ill=%0b ic=%0d lc=%0d trap=%0b imm=%h",
               cmd, illegal, instrCount, illegalCount, trap, imm);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h00432020, 1'b0);
    checks++;
    if (cmd !== 4'd9 || instrCount !== CW'(1) || rd !== 5'd4) begin
      failures++;
      $display("FAIL burst_resume: got cmd=%0d ic=%0d rd=%0d want 9/1/4", cmd, instrCount, rd);
    end
  endtask

  initial begin
    rst = 1'b1; irWe = 1'b0; instr = 32'h0; trapClr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_decode_sweep();
    test_hold();
    test_illegal();
    test_counters();
    test_random();
    test_reset_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Instruction register and decode stage of the multicycle CPU.
- Latches the fetched memory word when the control FSM asserts irWe.
- Decodes opcode and funct into the 4-bit command code that the control FSM consumes, and exposes the register and immediate fields to the datapath.
- Keeps retired/illegal instruction counters and an optional sticky illegal-instruction trap.

Parameters:
- COUNT_W, 32, width of instrCount (wraps).
- ILL_W, 16, width of illegalCount (saturates).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- irWe  input  1  instruction register write enable from control FSM.
- instr  input  32  memory read data (fetched word).
- trapClr  input  1  clears sticky trap (used only when ILLEGAL_TRAP_EN is defined).
- cmd  output  4  decoded command: LW=0 SW=1 J=2 JR=3 JAL=4 BEQ=5 BNE=6 XORI=7 ADDI=8 ADD=9 SUB=10 SLT=11 ILLEGAL=15.
- rs  output  5  IR[25:21].
- rt  output  5  IR[20:16].
- rd  output  5  IR[15:11].
- imm  output  16  IR[15:0].
- jaddr  output  26  IR[25:0].
- illegal  output  1  high while the latched instruction is unsupported.
- instrCount  output  COUNT_W  number of irWe-latched instructions.
- illegalCount  output  ILL_W  number of latched illegal instructions.
- trap  output  1  sticky illegal flag.

Behaviour:
Interface:
- One clock, clk.
- Reset rst is asynchronous and active-high.

Reset values:
- IR = 0.
- cmd = 4'hF.
- illegal = 0.
- instrCount = 0.
- illegalCount = 0.
- trap = 0.

IR latch and decode:
- At posedge with irWe=1: IR <= instr.
- In the same edge, cmd and illegal are registered from decode(instr), not from the old IR.
- Latency: exactly one cycle from irWe edge to valid cmd/fields.
- With irWe=0 all decode outputs hold.

Field outputs:
- rs, rt, rd, imm and jaddr are combinational slices of IR.

Decode table (op=instr[31:26], funct=instr[5:0]):
- op 0x23 -> LW.
- op 0x2B -> SW.
- op 0x02 -> J.
- op 0x03 -> JAL.
- op 0x04 -> BEQ.
- op 0x05 -> BNE.
- op 0x0E -> XORI.
- op 0x08 -> ADDI.
- op 0x00 with funct 0x08 -> JR.
- op 0x00 with funct 0x20 -> ADD.
- op 0x00 with funct 0x22 -> SUB.
- op 0x00 with funct 0x2A -> SLT.
- Any other op, or op 0x00 with any other funct (including all-zero word), -> cmd=15, illegal=1.
- Otherwise illegal=0.

instrCount:
- +1 on every irWe edge.
- Wraps from all-ones to 0.

illegalCount:
- +1 on every irWe edge whose instr decodes illegal.
- Saturates at all-ones; holds there.

Simultaneous events:
- irWe high on consecutive cycles: each edge latches and counts independently.

Reset mid-operation:
- rst asserted at any time forces reset values immediately, regardless of clk.
- First irWe edge after rst deassertion behaves normally.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined:
  - trap sets at the irWe edge that latches an illegal instruction.
  - trap stays set until a posedge with trapClr=1.
  - If set and clear occur on the same edge, set wins (trap stays 1).
  - trap is cleared by rst.
- Not defined:
  - trap tied to 0.
  - trapClr ignored.
  - No trap flop is synthesized.

Test Plan:
1. Reset: assert rst mid-cycle with no clock edge -> cmd=15, illegal=0, instrCount=0, illegalCount=0, trap=0 immediately.
2. Decode sweep: irWe pulse per word 0x8C430004, 0xAC430004, 0x08000010, 0x0C000010, 0x03E00008, 0x10430002, 0x14430002, 0x3843FFFF, 0x20430005, 0x00432020, 0x00432022, 0x0043202A:
   - cmd = 0,1,2,4,3,5,6,7,8,9,10,11 one cycle after each pulse.
   - rs=2, rt=3 where applicable.
   - imm=0xFFFF for XORI.
   - instrCount=12.
3. Hold: irWe=0 while instr changes to 0x00000000 -> cmd, IR fields and counters unchanged.
4. Illegal: latch 0x00000000 then 0xFC000000 -> cmd=15, illegal=1, illegalCount=2.
   - With ILLEGAL_TRAP_EN: trap=1, and it stays 1 through a following legal ADD.
   - Then trapClr pulse -> trap=0.
   - Same-edge illegal latch plus trapClr -> trap=1.
5. Counters: preload via 2^ILL_W+3 illegal latches with ILL_W=4 -> illegalCount stays 15. COUNT_W=4 with 17 latches -> instrCount=1.
6. Reset during burst: rst asserted between two irWe edges -> all outputs at reset values. Next latch of 0x00432020 -> cmd=9, instrCount=1.
